// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - oversampling UART receiver with 2-of-3 majority voting; optional parity via UART_RX_PARITY_EN
`timescale 1ns/1ps
module uart_rx_ovs #(
   parameter int CLOCK_FREQUENCY = 50_000_000,
   parameter int BAUD_RATE       = 9600,
   parameter int OVERSAMPLE      = 16,
   parameter int DATA_BITS       = 8,
   parameter int STOP_BITS       = 1,
   parameter int PARITY_ODD      = 0
) (
   input  logic                 clockIN,
   input  logic                 nRxResetIN,
   input  logic                 rxIN,
   input  logic                 rxReadyIN,
   output logic                 rxValidOUT,
   output logic [DATA_BITS-1:0] rxDataOUT,
   output logic                 rxIdleOUT,
   output logic                 rxFrameErrOUT,
   output logic                 rxParityErrOUT,
   output logic                 rxOverrunOUT
);

   localparam int DIV_VAL = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE) - 1;
   localparam int DIV_W   = (DIV_VAL < 1) ? 1 : $clog2(DIV_VAL + 1);
   localparam int TICK_W  = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV_VAL);
   localparam logic [TICK_W-1:0] T_S0     = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] T_S1     = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] T_RES    = TICK_W'(OVERSAMPLE / 2 + 1);
   localparam logic [TICK_W-1:0] T_END    = TICK_W'(OVERSAMPLE - 1);
   localparam logic [3:0]        B_LAST   = 4'(DATA_BITS - 1);
   localparam logic [3:0]        S_LAST   = 4'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   logic                 rx_meta, rx_sync, rx_prev;
   logic [2:0]           state;
   logic [DIV_W-1:0]     div_cnt;
   logic [TICK_W-1:0]    tick_cnt;
   logic [3:0]           bit_cnt;
   logic                 samp0, samp1;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 ferr_acc;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
   logic                 parity_err_now;
`endif

   logic tick, at_s0, at_s1, at_res, at_end;
   logic majority, start_edge, done, frame_err_now;

   assign tick       = (state != S_IDLE) && (div_cnt == DIV_LAST);
   assign at_s0      = tick && (tick_cnt == T_S0);
   assign at_s1      = tick && (tick_cnt == T_S1);
   assign at_res     = tick && (tick_cnt == T_RES);
   assign at_end     = tick && (tick_cnt == T_END);
   // Third vote is the live sample at the resolve tick.
   assign majority   = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);
   assign start_edge = (state == S_IDLE) && rx_prev && !rx_sync;
   assign done       = (state == S_STOP) && at_res && (bit_cnt == S_LAST);
   assign frame_err_now = ferr_acc | ~majority;
   assign rxIdleOUT  = (state == S_IDLE);

`ifdef UART_RX_PARITY_EN
   assign parity_err_now = ((^shift_reg) ^ par_bit) != 1'(PARITY_ODD);
`else
   logic unused_cfg;
   assign unused_cfg     = 1'(PARITY_ODD);
   assign rxParityErrOUT = 1'b0;
`endif

   // Two-flop synchroniser plus one history flop for falling-edge detection.
   always_ff @(posedge clockIN or negedge nRxResetIN) begin
      if (!nRxResetIN) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rxIN;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Oversample tick divider, parked at zero while idle.
   always_ff @(posedge clockIN or negedge nRxResetIN) begin
      if (!nRxResetIN) begin
         div_cnt <= '0;
      end else if (state == S_IDLE || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Frame FSM: tick position within the bit, vote samples, shifting and stop checking.
   always_ff @(posedge clockIN or negedge nRxResetIN) begin
      if (!nRxResetIN) begin
         state     <= S_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         samp0     <= 1'b0;
         samp1     <= 1'b0;
         shift_reg <= '0;
         ferr_acc  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else if (state == S_IDLE) begin
         if (start_edge) begin
            state    <= S_START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            ferr_acc <= 1'b0;
         end
      end else begin
         if (tick) begin
            tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + 1'b1;
         end
         if (at_s0) samp0 <= rx_sync;
         if (at_s1) samp1 <= rx_sync;
         case (state)
            S_START: begin
               if (at_res && majority) begin
                  state <= S_IDLE;
               end else if (at_end) begin
                  state   <= S_DATA;
                  bit_cnt <= '0;
               end
            end
            S_DATA: begin
               if (at_res) shift_reg <= {majority, shift_reg[DATA_BITS-1:1]};
               if (at_end) begin
                  if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (at_res) par_bit <= majority;
               if (at_end) state <= S_STOP;
            end
`endif
            S_STOP: begin
               if (at_res) begin
                  ferr_acc <= frame_err_now;
                  if (bit_cnt == S_LAST) state <= S_IDLE;
               end
               if (at_end) bit_cnt <= bit_cnt + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Holding register with valid/ready handshake and sticky overrun.
   always_ff @(posedge clockIN or negedge nRxResetIN) begin
      if (!nRxResetIN) begin
         rxValidOUT     <= 1'b0;
         rxDataOUT      <= '0;
         rxFrameErrOUT  <= 1'b0;
         rxOverrunOUT   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         rxParityErrOUT <= 1'b0;
`endif
      end else begin
         if (rxValidOUT && rxReadyIN) rxOverrunOUT <= 1'b0;
         if (done && (!rxValidOUT || rxReadyIN)) begin
            rxValidOUT     <= 1'b1;
            rxDataOUT      <= shift_reg;
            rxFrameErrOUT  <= frame_err_now;
`ifdef UART_RX_PARITY_EN
            rxParityErrOUT <= parity_err_now;
`endif
         end else if (done) begin
            rxOverrunOUT <= 1'b1;
         end else if (rxValidOUT && rxReadyIN) begin
            rxValidOUT <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - self-checking bench for uart_rx_ovs at 16 clk/tick, 256 clk/bit
`timescale 1ns/1ps
module tb_uart_rx_ovs;
   localparam int BIT_CLK = 256;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       ready;
   logic       valid;
   logic [7:0] data;
   logic       idle_o, fe, pe, ov;

   always #5 clk = ~clk;

   uart_rx_ovs #(
      .CLOCK_FREQUENCY(16_000_000),
      .BAUD_RATE(62_500),
      .OVERSAMPLE(16),
      .DATA_BITS(8),
      .STOP_BITS(1),
      .PARITY_ODD(0)
   ) dut (
      .clockIN(clk),
      .nRxResetIN(rst_n),
      .rxIN(rx),
      .rxReadyIN(ready),
      .rxValidOUT(valid),
      .rxDataOUT(data),
      .rxIdleOUT(idle_o),
      .rxFrameErrOUT(fe),
      .rxParityErrOUT(pe),
      .rxOverrunOUT(ov)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } word_t;

   typedef struct {
      logic [7:0] data;
      logic       stop_b;
      logic [7:0] exp_data;
      logic       exp_fe;
   } vec_t;

   word_t got_q[$];
   word_t exp_q[$];
   int    valid_cycles = 0;
   int    n_vec = 0;
   int    n_err = 0;

   // Record every accepted word and every cycle the output is valid.
   always @(negedge clk) begin
      if (valid === 1'b1) valid_cycles++;
      if (valid === 1'b1 && ready === 1'b1) got_q.push_back(word_t'({data, fe, pe}));
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic idle_line(input int nclk);
      rx = 1'b1;
      repeat (nclk) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par_b);
`endif
      drive_bit(stop_b);
      rx = 1'b1;
   endtask

   task automatic expect_one(input string name, input int base, input logic [7:0] ed,
                             input logic efe, input logic epe);
      check($sformatf("%s words", name), 32'(got_q.size() - base), 32'd1);
      if (got_q.size() > base) begin
         check($sformatf("%s data", name), 32'(got_q[base].d), 32'(ed));
         check($sformatf("%s frame_err", name), 32'(got_q[base].fe), 32'(efe));
         check($sformatf("%s parity_err", name), 32'(got_q[base].pe), 32'(epe));
      end
   endtask

   vec_t vecs[6];

   initial begin
      int base;
      int vc0;
      logic [7:0] d;
      logic stop_b;
      int gap;

      vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
      vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
      vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
      vecs[4] = '{8'h81, 1'b0, 8'h81, 1'b1};
      vecs[5] = '{8'h5A, 1'b1, 8'h5A, 1'b0};

      rst_n = 1'b0;
      rx    = 1'b1;
      ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset valid", 32'(valid), 32'd0);
      check("reset data", 32'(data), 32'd0);
      check("reset idle", 32'(idle_o), 32'd1);
      check("reset flags", 32'({fe, pe, ov}), 32'd0);
      rst_n = 1'b1;
      idle_line(2 * BIT_CLK);

      // Table-driven frames with the consumer always ready.
      for (int i = 0; i < 6; i++) begin
         base = got_q.size();
         vc0  = valid_cycles;
         send_frame(vecs[i].data, vecs[i].stop_b, ^vecs[i].data);
         idle_line(2 * BIT_CLK);
         expect_one($sformatf("vec%0d", i), base, vecs[i].exp_data, vecs[i].exp_fe, 1'b0);
         check($sformatf("vec%0d pulse", i), 32'(valid_cycles - vc0), 32'd1);
      end

      // Short low glitch must be rejected as a false start.
      vc0 = valid_cycles;
      rx  = 1'b0;
      repeat (48) @(negedge clk);
      check("glitch in start", 32'(idle_o), 32'd0);
      idle_line(3 * BIT_CLK);
      check("glitch idle", 32'(idle_o), 32'd1);
      check("glitch no word", 32'(valid_cycles - vc0), 32'd0);

      // Break: line low for two frame times yields a single errored word.
      base = got_q.size();
      rx   = 1'b0;
      repeat (20 * BIT_CLK) @(negedge clk);
      idle_line(3 * BIT_CLK);
      expect_one("break", base, 8'h00, 1'b1, 1'b0);

      // Overrun: two frames while the consumer is stalled.
      ready = 1'b0;
      send_frame(8'h11, 1'b1, ^8'h11);
      send_frame(8'h22, 1'b1, ^8'h22);
      idle_line(BIT_CLK);
      check("ovr valid", 32'(valid), 32'd1);
      check("ovr data", 32'(data), 32'h11);
      check("ovr flag", 32'(ov), 32'd1);
      ready = 1'b1;
      @(negedge clk);
      check("ovr valid cleared", 32'(valid), 32'd0);
      check("ovr flag cleared", 32'(ov), 32'd0);
      idle_line(BIT_CLK);

      // Reset in the middle of the data bits abandons the frame.
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      check("midreset busy", 32'(idle_o), 32'd0);
      rst_n = 1'b0;
      #2;
      check("midreset valid", 32'(valid), 32'd0);
      check("midreset data", 32'(data), 32'd0);
      check("midreset idle", 32'(idle_o), 32'd1);
      check("midreset flags", 32'({fe, pe, ov}), 32'd0);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      idle_line(2 * BIT_CLK);
      base = got_q.size();
      send_frame(8'h5A, 1'b1, ^8'h5A);
      idle_line(2 * BIT_CLK);
      expect_one("after reset", base, 8'h5A, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
      base = got_q.size();
      send_frame(8'h07, 1'b1, 1'b0);
      idle_line(2 * BIT_CLK);
      expect_one("parity bad", base, 8'h07, 1'b0, 1'b1);
      base = got_q.size();
      send_frame(8'h07, 1'b1, 1'b1);
      idle_line(2 * BIT_CLK);
      expect_one("parity good", base, 8'h07, 1'b0, 1'b0);
`endif

      // Random frames against a queue model: each frame yields its payload, error iff stop bit low.
      base = got_q.size();
      for (int k = 0; k < 10; k++) begin
         d      = 8'($urandom_range(0, 255));
         stop_b = ($urandom_range(0, 4) != 0);
         gap    = $urandom_range(0, 300);
         if (!stop_b && gap < 32) gap = 32;
         exp_q.push_back(word_t'({d, ~stop_b, 1'b0}));
         send_frame(d, stop_b, ^d);
         idle_line(gap);
      end
      idle_line(2 * BIT_CLK);
      check("random count", 32'(got_q.size() - base), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         if (base + k < got_q.size())
            check($sformatf("random word%0d", k), 32'(got_q[base + k]), 32'(exp_q[k]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
